// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings (common with the TX side) and frame width.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    START     = 4'd1,
    DATA      = 4'd2,
    PARITY    = 4'd3,
    STOP      = 4'd4,
    WR_SETUP  = 4'd5,
    WR_CLK_P  = 4'd6,
    WR_CLK_N  = 4'd7,
    WAIT_HIGH = 4'd8
  } uart_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous RX line; resets to the idle (high) level.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      meta <= rx;
      rx_s <= meta;
    end
  end

endmodule

// File: rtl/uart_fifo_receiver.sv
// Oversampling 8N1 UART receiver that writes good bytes into the RX FIFO with a WE/CLK pulse sequence.
// Optional parity (one bit after the data) is compiled in with `define UART_RX_PARITY_EN.
module uart_fifo_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic       UART_CLK,
  input  logic       nRST,
  input  logic       UART_RX,
  output logic       FIFO_CLK,
  output logic       FIFO_WE,
  input  logic       FIFO_Full,
  output logic [7:0] FIFO_Data,
  output logic       Frame_Err,
`ifdef UART_RX_PARITY_EN
  output logic       Parity_Err,
`endif
  output logic       Overrun
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  if (OVERSAMPLE < 8 || (1 << CNT_W) <= OVERSAMPLE || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
    $error("uart_fifo_receiver: illegal OVERSAMPLE/CNT_W/PARITY_ODD combination");
  end

  uart_state_t          state;
  logic                 rx_s;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit;
  logic                 par_bad;

  assign par_bad = ((^shift) ^ (PARITY_ODD != 0)) != par_bit;
`endif

  uart_rx_sync u_sync (
    .clk  (UART_CLK),
    .rst_n(nRST),
    .rx   (UART_RX),
    .rx_s (rx_s)
  );

  // Outputs are registered, so each write-sequence state drives its FIFO
  // signals one cycle after it is entered: WE leads CLK by a cycle and both drop together.
  always_ff @(posedge UART_CLK) begin
    if (!nRST) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      FIFO_CLK  <= 1'b0;
      FIFO_WE   <= 1'b0;
      FIFO_Data <= 8'h00;
      Frame_Err <= 1'b0;
      Overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      Parity_Err <= 1'b0;
`endif
    end else begin
      Frame_Err <= 1'b0;
      Overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      Parity_Err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!rx_s) begin
            cnt   <= '0;
            state <= START;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            if (rx_s) begin
              state <= IDLE;
            end else begin
              cnt     <= '0;
              bit_idx <= '0;
              state   <= DATA;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shift   <= {rx_s, shift[DATA_BITS-1:1]};
            bit_idx <= bit_idx + IDX_W'(1);
            if (bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            par_bit <= rx_s;
            state   <= STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`endif
        // A bad stop bit outranks every other outcome; otherwise the byte is dropped or written.
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (!rx_s) begin
              Frame_Err <= 1'b1;
              state     <= WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
            end else if (par_bad) begin
              Parity_Err <= 1'b1;
              state      <= IDLE;
`endif
            end else if (FIFO_Full) begin
              Overrun <= 1'b1;
              state   <= IDLE;
            end else begin
              FIFO_Data <= shift;
              state     <= WR_SETUP;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WR_SETUP: begin
          FIFO_WE <= 1'b1;
          state   <= WR_CLK_P;
        end
        WR_CLK_P: begin
          FIFO_CLK <= 1'b1;
          state    <= WR_CLK_N;
        end
        WR_CLK_N: begin
          FIFO_CLK <= 1'b0;
          FIFO_WE  <= 1'b0;
          state    <= IDLE;
        end
        WAIT_HIGH: begin
          if (rx_s) state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          bit_idx   <= '0;
          shift     <= '0;
          FIFO_CLK  <= 1'b0;
          FIFO_WE   <= 1'b0;
          FIFO_Data <= 8'h00;
          Frame_Err <= 1'b0;
          Overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
          par_bit    <= 1'b0;
          Parity_Err <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_fifo_receiver.sv
// Self-checking bench for uart_fifo_receiver: directed vector table, hand-written corner sequences
// and randomized frames checked against a frame-level reference model.
module tb_uart_fifo_receiver;

  localparam int OS     = 16;
  localparam int PERIOD = 10;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  // Start edge to FIFO_CLK high: 2 sync + 1 idle detect + half bit + data (+parity) + stop + 2 write cycles.
  localparam int LATENCY = 2 + 1 + OS / 2 + 8 * OS + PAR_BITS * OS + OS + 2;

  logic       UART_CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       UART_RX = 1'b1;
  logic       FIFO_Full = 1'b0;
  logic       FIFO_CLK;
  logic       FIFO_WE;
  logic [7:0] FIFO_Data;
  logic       Frame_Err;
  logic       Overrun;
`ifdef UART_RX_PARITY_EN
  logic       Parity_Err;
`endif

  always #(PERIOD / 2) UART_CLK = ~UART_CLK;

  uart_fifo_receiver #(.OVERSAMPLE(OS), .CNT_W(8), .PARITY_ODD(0)) dut (
    .UART_CLK  (UART_CLK),
    .nRST      (nRST),
    .UART_RX   (UART_RX),
    .FIFO_CLK  (FIFO_CLK),
    .FIFO_WE   (FIFO_WE),
    .FIFO_Full (FIFO_Full),
    .FIFO_Data (FIFO_Data),
    .Frame_Err (Frame_Err),
`ifdef UART_RX_PARITY_EN
    .Parity_Err(Parity_Err),
`endif
    .Overrun   (Overrun)
  );

  int checks = 0;
  int failures = 0;

  // Monitor state, sampled on the falling edge away from the DUT's active edge.
  logic [7:0] wr_q[$];
  int  wr_cnt = 0, fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
  int  width_err = 0, setup_err = 0, we_err = 0, both_err = 0, pulse_err = 0;
  logic clk_prev = 1'b0, we_prev = 1'b0, fe_prev = 1'b0, ov_prev = 1'b0;
  time start_time = 0, last_rise_time = 0;
  logic [7:0] last_data = 8'h00;

  always @(negedge UART_CLK) begin
    if (FIFO_CLK && !clk_prev) begin
      wr_q.push_back(FIFO_Data);
      wr_cnt++;
      last_rise_time = $time;
      if (!FIFO_WE) we_err++;
      if (!we_prev) setup_err++;
    end
    if (FIFO_CLK && clk_prev) width_err++;
    if (Frame_Err) fe_cnt++;
    if (Overrun) ov_cnt++;
    if (Frame_Err && Overrun) both_err++;
    if ((Frame_Err && fe_prev) || (Overrun && ov_prev)) pulse_err++;
`ifdef UART_RX_PARITY_EN
    if (Parity_Err) pe_cnt++;
`endif
    clk_prev = FIFO_CLK;
    we_prev  = FIFO_WE;
    fe_prev  = Frame_Err;
    ov_prev  = Overrun;
  end

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge UART_CLK);
  endtask

  task automatic send_bit(input logic b);
    UART_RX = b;
    idle(OS);
  endtask

  task automatic send_frame(input logic [7:0] data, input bit stop_ok, input int low_hold, input bit par_bad);
    start_time = $time;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^data) ^ par_bad);
`endif
    if (stop_ok) begin
      send_bit(1'b1);
    end else begin
      UART_RX = 1'b0;
      idle(low_hold);
      UART_RX = 1'b1;
    end
  endtask

  // Frame-level reference: bad stop wins, then parity, then FIFO full, else the byte is written.
  function automatic void model(input bit stop_ok, input bit par_bad, input bit full,
                                output bit w, output bit fe, output bit ov, output bit pe);
    w = 0; fe = 0; ov = 0; pe = 0;
    if (!stop_ok)     fe = 1;
    else if (par_bad) pe = 1;
    else if (full)    ov = 1;
    else              w  = 1;
  endfunction

  task automatic apply_stimulus(input string tag, input logic [7:0] data, input bit stop_ok, input bit full,
                                input int low_hold, input bit par_bad, input bit exp_w, input bit exp_fe,
                                input bit exp_ov, input bit exp_pe);
    int w0, fe0, ov0, pe0, got;
    wr_q.delete();
    w0 = wr_cnt; fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
    FIFO_Full = full;
    send_frame(data, stop_ok, low_hold, par_bad);
    idle(24);
    FIFO_Full = 1'b0;
    check_output({tag, "_writes"}, wr_cnt - w0, int'(exp_w));
    check_output({tag, "_frame_err"}, fe_cnt - fe0, int'(exp_fe));
    check_output({tag, "_overrun"}, ov_cnt - ov0, int'(exp_ov));
`ifdef UART_RX_PARITY_EN
    check_output({tag, "_parity_err"}, pe_cnt - pe0, int'(exp_pe));
`endif
    if (exp_w) begin
      got = (wr_q.size() > 0) ? int'(wr_q[0]) : -1;
      check_output({tag, "_data"}, got, int'(data));
      check_output({tag, "_latency"}, int'((last_rise_time - start_time) / PERIOD), LATENCY);
      last_data = data;
    end else begin
      check_output({tag, "_data_hold"}, int'(FIFO_Data), int'(last_data));
    end
  endtask

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    bit         full;
    int         low_hold;
    bit         exp_w;
    bit         exp_fe;
    bit         exp_ov;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #(PERIOD * 100000);
    $display("[TB] FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int w0;
    logic [7:0] c3;
    logic [7:0] b2b[3];
    bit ew, efe, eov, epe, st, fl, pb;
    logic [7:0] d;

    vecs[0] = '{8'hA5, 1'b1, 1'b0, OS, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h55, 1'b0, 1'b0, 40, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h81, 1'b1, 1'b0, OS, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h12, 1'b1, 1'b1, OS, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'h34, 1'b1, 1'b0, OS, 1'b1, 1'b0, 1'b0};

    nRST = 1'b0;
    idle(5);
    check_output("reset_fifo_clk", int'(FIFO_CLK), 0);
    check_output("reset_fifo_we", int'(FIFO_WE), 0);
    check_output("reset_fifo_data", int'(FIFO_Data), 0);
    check_output("reset_frame_err", int'(Frame_Err), 0);
    check_output("reset_overrun", int'(Overrun), 0);
    nRST = 1'b1;
    idle(10);

    for (int i = 0; i < 5; i++) begin
      apply_stimulus($sformatf("vec%0d", i), vecs[i].data, vecs[i].stop_ok, vecs[i].full,
                     vecs[i].low_hold, 1'b0, vecs[i].exp_w, vecs[i].exp_fe, vecs[i].exp_ov, 1'b0);
    end

    // Short low glitch must not start a frame; a real frame right after must still be received.
    w0 = wr_cnt;
    UART_RX = 1'b0;
    idle(4);
    UART_RX = 1'b1;
    idle(40);
    check_output("glitch_writes", wr_cnt - w0, 0);
    apply_stimulus("after_glitch", 8'h3C, 1'b1, 1'b0, OS, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    b2b[0] = 8'h00; b2b[1] = 8'hFF; b2b[2] = 8'h7E;
    wr_q.delete();
    w0 = wr_cnt;
    for (int k = 0; k < 3; k++) send_frame(b2b[k], 1'b1, OS, 1'b0);
    idle(24);
    check_output("b2b_writes", wr_cnt - w0, 3);
    for (int k = 0; k < 3; k++) begin
      check_output($sformatf("b2b_data%0d", k), (wr_q.size() > k) ? int'(wr_q[k]) : -1, int'(b2b[k]));
    end
    last_data = 8'h7E;

    // Reset in the middle of bit 4 of 0xC3 discards the partial byte and clears the outputs.
    c3 = 8'hC3;
    w0 = wr_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(c3[i]);
    UART_RX = c3[4];
    idle(8);
    nRST = 1'b0;
    UART_RX = 1'b1;
    idle(3);
    check_output("midreset_fifo_data", int'(FIFO_Data), 0);
    check_output("midreset_fifo_we", int'(FIFO_WE), 0);
    check_output("midreset_fifo_clk", int'(FIFO_CLK), 0);
    nRST = 1'b1;
    idle(30);
    check_output("midreset_writes", wr_cnt - w0, 0);
    last_data = 8'h00;
    apply_stimulus("after_reset", 8'h9A, 1'b1, 1'b0, OS, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef UART_RX_PARITY_EN
    apply_stimulus("parity_bad", 8'h07, 1'b1, 1'b0, OS, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    apply_stimulus("parity_good", 8'h07, 1'b1, 1'b0, OS, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

    for (int r = 0; r < 16; r++) begin
      d  = 8'($urandom);
      st = ($urandom_range(0, 4) != 0);
      fl = ($urandom_range(0, 4) == 0);
`ifdef UART_RX_PARITY_EN
      pb = ($urandom_range(0, 4) == 0);
`else
      pb = 1'b0;
`endif
      model(st, pb, fl, ew, efe, eov, epe);
      idle($urandom_range(0, 7));
      apply_stimulus($sformatf("rand%0d", r), d, st, fl, OS + $urandom_range(0, 24), pb, ew, efe, eov, epe);
    end

    check_output("fifo_clk_width_errors", width_err, 0);
    check_output("we_setup_errors", setup_err, 0);
    check_output("we_during_clk_errors", we_err, 0);
    check_output("err_same_cycle", both_err, 0);
    check_output("err_pulse_width", pulse_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_fifo_receiver.md
Name: uart_fifo_receiver

Overview:
UART receive path, the counterpart of the UART transmit path.
- Oversamples the UART_RX line and deframes 8N1 bytes, LSB first.
- Writes each good byte into the RX FIFO using the same FIFO_CLK pulse protocol the transmit side uses for reads.
- Flags framing and overrun errors.
- Sits between the board RX pin and the RX FIFO, in the UART_CLK domain.

Parameters:
OVERSAMPLE, 16, UART_CLK cycles per bit; must be ≥8.
CNT_W, 8, width of the sample counter; 2^CNT_W must be greater than OVERSAMPLE.
PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd.

Ports:
UART_CLK  input  1  block clock, baud × OVERSAMPLE
nRST  input  1  reset, synchronous, active-low
UART_RX  input  1  asynchronous serial line, idle high
FIFO_CLK  output  1  FIFO write clock pulse
FIFO_WE  output  1  FIFO write enable
FIFO_Full  input  1  FIFO full flag
FIFO_Data  output  8  byte to write
Frame_Err  output  1  one-cycle pulse: bad stop bit
Overrun  output  1  one-cycle pulse: byte dropped because the FIFO was full

Behaviour:
Interface:
- One clock, UART_CLK.
- nRST is synchronous and active-low. It is sampled only on the UART_CLK rising edge.

Reset values:
- FIFO_CLK=0, FIFO_WE=0, FIFO_Data=8'h00, Frame_Err=0, Overrun=0.
- State=IDLE, counters=0.
- Synchroniser flops reset to 1.
- Reset mid-byte discards the partial byte. No FIFO write occurs.

Input synchroniser:
- UART_RX passes through 2 flops; the output is rx_s.
- All decisions use rx_s.

State machine:
- IDLE: when rx_s=0, clear the sample counter and go to START.
- START: count to OVERSAMPLE/2−1, then sample rx_s.
  - rx_s=1: glitch; return to IDLE.
  - rx_s=0: clear the counter and bit index; go to DATA.
- DATA: at count=OVERSAMPLE−1, shift rx_s into shift-register bit 7 with a right shift, and increment the bit index. After the 8th bit, go to STOP, or to PARITY if compiled in.
- STOP: at count=OVERSAMPLE−1, sample rx_s.
  - rx_s=0: pulse Frame_Err for 1 cycle and go to WAIT_HIGH. Nothing is written.
  - rx_s=1 and FIFO_Full=1: pulse Overrun for 1 cycle, drop the byte, go to IDLE.
  - rx_s=1 and FIFO_Full=0: load FIFO_Data from the shift register and go to WR_SETUP.
- WR_SETUP: FIFO_WE=1, FIFO_Data stable. Go to WR_CLK_P.
- WR_CLK_P: FIFO_CLK=1. Go to WR_CLK_N.
- WR_CLK_N: FIFO_CLK=0, FIFO_WE=0. Go to IDLE.
- WAIT_HIGH: stay until rx_s=1, then go to IDLE. A break condition therefore never produces repeated bytes.

Write timing and latency:
- FIFO_WE rises 1 cycle after the stop sample.
- FIFO_CLK is high exactly 1 cycle.
- FIFO_Data holds its value until the next load.
- Latency from the stop-bit midpoint to the FIFO_CLK rising edge is 2 cycles, plus 2 synchroniser cycles on the line.
- The write sequence takes 3 cycles, which is less than OVERSAMPLE/2. It always completes before the next start edge can arrive, so back-to-back frames with 1 stop bit are never missed.

Error and edge rules:
- FIFO_Full is sampled only in STOP.
- Frame_Err and Overrun never assert in the same cycle.
- Unused state encodings go to IDLE with all outputs at their reset values.

Optional Feature:
Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA. It samples one bit at count=OVERSAMPLE−1.
  - Parity is computed as the XOR of the 8 data bits, XORed with PARITY_ODD.
  - On mismatch, the byte is dropped and port Parity_Err (output, 1 bit, reset 0) pulses for 1 cycle in STOP, instead of a write.
  - A bad stop bit takes precedence: Frame_Err is reported, not Parity_Err.
- Undefined: 8N1 only. Neither the PARITY state nor the Parity_Err port exists.

Decomposition:
- Package uart_pkg holds:
  - the state encoding constants, shared with the TX FSM encoding space: IDLE, START, DATA, PARITY, STOP, WR_SETUP, WR_CLK_P, WR_CLK_N, WAIT_HIGH;
  - DATA_BITS=8.
- One sub-module, uart_rx_sync: the 2-flop synchroniser with reset value 1.
- The FSM, counters and shift register stay in the top module.

Test Plan:
All scenarios use OVERSAMPLE=16.
- Frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first), FIFO_Full=0 → exactly one FIFO_CLK pulse, with FIFO_WE=1 and FIFO_Data=8'hA5 during it. No error pulses.
- UART_RX low for 4 cycles, then high → no FIFO_WE, state back in IDLE. A following 0x3C frame is received correctly.
- Frame 0x55 with stop bit forced 0, line held low for 40 cycles, then high → one Frame_Err pulse, no write. A following 0x81 frame is received correctly.
- FIFO_Full=1 during frame 0x12 → one Overrun pulse, FIFO_WE stays 0. With FIFO_Full=0, the next frame 0x34 writes 8'h34.
- Back-to-back frames 0x00, 0xFF, 0x7E with 1 stop bit and no gap → three writes in order: 00, FF, 7E.
- nRST low during bit 4 of 0xC3, released, then frame 0x9A sent → no write of partial data, one write of 8'h9A.
- With UART_RX_PARITY_EN defined and PARITY_ODD=0: frame 0x07 with parity bit 0 → one Parity_Err pulse, no write. The same frame with parity bit 1 → write of 8'h07.
